// File: rtl/fft_stage_sequencer_pkg.sv
// fft_seq_pkg: shared types and constants for the twiddle-stage sequencer.
//   seq_state_t : sequencer FSM states (IDLE, FILL, RUN, DRAIN)
//   FRAME_DEF   : default cycles per frame (N=128 over 4 lanes)
//   ADDR_W_DEF  : default twiddle address width, clog2(FRAME_DEF)
//   log2_pow2() : log2 of a power-of-two commutator delay
package fft_seq_pkg;

  localparam int FRAME_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Exact for powers of two; the commutator select bit is this index.
  function automatic int log2_pow2(input int d);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < d) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: control bundle between the saturator front end,
// the sequencer and the two twiddle stages.
//   in_valid    : frame-valid strobe from the front end
//   st_en       : per-stage enables (bit0 stage V, bit1 stage VI)
//   bf_ctrl     : commutator select per stage
//   tw_addr0/1  : twiddle ROM addresses for stage V / VI
//   out_valid   : output register holds valid data
//   frame_start : first valid output of a frame
//   busy        : pipeline not empty
//   err_partial : input frame was cut short
// Modports: master drives in_valid and observes the rest; slave is the sequencer.
interface fft_stage_sequencer_if #(
  parameter int ADDR_W = fft_seq_pkg::ADDR_W_DEF
);

  logic              in_valid;
  logic [1:0]        st_en;
  logic [1:0]        bf_ctrl;
  logic [ADDR_W-1:0] tw_addr0;
  logic [ADDR_W-1:0] tw_addr1;
  logic              out_valid;
  logic              frame_start;
  logic              busy;
  logic              err_partial;

  modport master (
    output in_valid,
    input  st_en, bf_ctrl, tw_addr0, tw_addr1,
    input  out_valid, frame_start, busy, err_partial
  );

  modport slave (
    input  in_valid,
    output st_en, bf_ctrl, tw_addr0, tw_addr1,
    output out_valid, frame_start, busy, err_partial
  );

endinterface

// File: rtl/fft_stage_sequencer_stage_ctl.sv
// fft_seq_stage_ctl: control for one twiddle stage.
//   clk, rst  : clock, synchronous active-high reset
//   en_in     : enable of the previous stage (or the input strobe)
//   en_out    : en_in delayed D cycles; this stage's enable
//   bf_ctrl   : commutator select, bit log2(D) of the stage counter
//   tw_addr   : twiddle ROM address, the stage counter
//   pipe_busy : some bit of the delay line is set
// Address and select are forced to 0 while the stage is disabled.
module fft_seq_stage_ctl
  import fft_seq_pkg::*;
#(
  parameter int D      = 1,
  parameter int FRAME  = FRAME_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  output logic              en_out,
  output logic              bf_ctrl,
  output logic [ADDR_W-1:0] tw_addr,
  output logic              pipe_busy
);

  localparam int SEL = log2_pow2(D);

  logic [D-1:0]      dly_q;
  logic [ADDR_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the delay line into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= '0;
      cnt_q <= '0;
    end else begin
      dly_q <= (dly_q << 1) | D'(en_in);
      // Counter is 0 in the first enabled cycle because it is held at 0
      // through every disabled cycle, so a bubble restarts the frame.
      if (en_out) begin
        cnt_q <= (cnt_q == ADDR_W'(FRAME - 1)) ? '0 : cnt_q + ADDR_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign en_out    = dly_q[D-1];
  assign tw_addr   = en_out ? cnt_q : '0;
  assign bf_ctrl   = en_out & cnt_q[SEL];
  assign pipe_busy = |dly_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: central sequencer for twiddle stages V and VI.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fft_stage_sequencer_if (in_valid in; stage
//              enables, commutator selects, twiddle addresses, out_valid,
//              frame_start, busy, err_partial out)
// in_valid ripples through stage V (D0), stage VI (D1) and OUT_DLY output
// registers. Every output comes from flops, never directly from in_valid.
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int D0      = 2,
  parameter int D1      = 1,
  parameter int FRAME   = FRAME_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OUT_DLY = 1
) (
  input logic                  clk,
  input logic                  rst,
  fft_stage_sequencer_if.slave bus
);

  logic              st_en0, st_en1;
  logic              bf0, bf1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              busy0, busy1;

  logic [OUT_DLY-1:0] out_q;
  logic [ADDR_W-1:0]  fi_q, fo_q;
  logic               err_q;
  logic               out_valid;
  logic               pipe_empty;
  seq_state_t         state_q, state_d;

  fft_seq_stage_ctl #(.D(D0), .FRAME(FRAME), .ADDR_W(ADDR_W)) u_stage_v (
    .clk       (clk),
    .rst       (rst),
    .en_in     (bus.in_valid),
    .en_out    (st_en0),
    .bf_ctrl   (bf0),
    .tw_addr   (addr0),
    .pipe_busy (busy0)
  );

  fft_seq_stage_ctl #(.D(D1), .FRAME(FRAME), .ADDR_W(ADDR_W)) u_stage_vi (
    .clk       (clk),
    .rst       (rst),
    .en_in     (st_en0),
    .en_out    (st_en1),
    .bf_ctrl   (bf1),
    .tw_addr   (addr1),
    .pipe_busy (busy1)
  );

  assign out_valid  = out_q[OUT_DLY-1];
  // out_q includes out_valid itself, so this also requires out_valid low.
  assign pipe_empty = ~(busy0 | busy1 | (|out_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      fi_q    <= '0;
      fo_q    <= '0;
      err_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      out_q   <= (out_q << 1) | OUT_DLY'(st_en1);
      // A drop with fi != 0 means the frame ended short; the flag lands in
      // the cycle after the low in_valid is sampled.
      err_q   <= ~bus.in_valid & (fi_q != '0);
      state_q <= state_d;
      if (bus.in_valid) begin
        fi_q <= (fi_q == ADDR_W'(FRAME - 1)) ? '0 : fi_q + ADDR_W'(1);
      end else begin
        fi_q <= '0;
      end
      if (out_valid) begin
        fo_q <= (fo_q == ADDR_W'(FRAME - 1)) ? '0 : fo_q + ADDR_W'(1);
      end else begin
        fo_q <= '0;
      end
    end
  end

  // NOTE: the next state gets a default before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid) state_d = FILL;
      FILL: begin
        if (out_valid)                        state_d = RUN;
        else if (!bus.in_valid && pipe_empty) state_d = IDLE;
      end
      RUN:   if (!bus.in_valid) state_d = DRAIN;
      DRAIN: begin
        if (bus.in_valid)    state_d = RUN;
        else if (pipe_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.st_en       = {st_en1, st_en0};
  assign bus.bf_ctrl     = {bf1, bf0};
  assign bus.tw_addr0    = addr0;
  assign bus.tw_addr1    = addr1;
  assign bus.out_valid   = out_valid;
  assign bus.frame_start = out_valid & (fo_q == '0);
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_partial = err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer (D0=2, D1=1, FRAME=32, OUT_DLY=1).
// Inputs are recorded per cycle; expected outputs are derived from that
// history (delays, run lengths modulo FRAME) and compared on every negedge.
// Directed scenarios add literal expectations on the recorded outputs.
module tb_fft_stage_sequencer;

  localparam int D0   = 2;
  localparam int D1   = 1;
  localparam int FR   = 32;
  localparam int AW   = 5;
  localparam int OD   = 1;
  localparam int TOT  = D0 + D1 + OD;
  localparam int SEL0 = 1;
  localparam int SEL1 = 0;
  localparam int MAXC = 4096;

  localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc = -1;
  int   n_checks = 0;
  int   n_fail = 0;

  fft_stage_sequencer_if #(.ADDR_W(AW)) bus ();

  fft_stage_sequencer #(
    .D0(D0), .D1(D1), .FRAME(FR), .ADDR_W(AW), .OUT_DLY(OD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  bit in_h  [MAXC];
  bit rst_h [MAXC];
  logic [1:0]    rec_st   [MAXC];
  logic [1:0]    rec_bf   [MAXC];
  logic [AW-1:0] rec_tw0  [MAXC];
  logic [AW-1:0] rec_tw1  [MAXC];
  logic          rec_ov   [MAXC];
  logic          rec_fs   [MAXC];
  logic          rec_busy [MAXC];
  logic          rec_err  [MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // in_valid as seen k cycles later through a chain of k flops.
  function automatic bit dly(input int k, input int n);
    if (n - k < 0) return 1'b0;
    for (int j = n - k; j < n; j++) if (rst_h[j]) return 1'b0;
    return in_h[n - k];
  endfunction

  // Consecutive cycles, ending at n, in which the k-delayed strobe is high.
  function automatic int run_len(input int k, input int n);
    int m;
    m = 0;
    while (n - m >= 0 && dly(k, n - m)) m++;
    return m;
  endfunction

  // Input frame count held during cycle m.
  function automatic int fi_at(input int m);
    int c, j;
    c = 0;
    j = m - 1;
    while (j >= 0 && in_h[j] && !rst_h[j]) begin
      c++;
      j--;
    end
    return c % FR;
  endfunction

  int  mn;
  int  ms = M_IDLE;
  bit  e_st0, e_st1, e_ov, e_fs, e_err, e_empty;
  int  e_tw0, e_tw1;

  always @(negedge clk) begin
    if (cyc >= 0 && cyc < MAXC) begin
      mn = cyc;
      in_h[mn]     = bus.in_valid;
      rst_h[mn]    = rst;
      rec_st[mn]   = bus.st_en;
      rec_bf[mn]   = bus.bf_ctrl;
      rec_tw0[mn]  = bus.tw_addr0;
      rec_tw1[mn]  = bus.tw_addr1;
      rec_ov[mn]   = bus.out_valid;
      rec_fs[mn]   = bus.frame_start;
      rec_busy[mn] = bus.busy;
      rec_err[mn]  = bus.err_partial;

      e_st0 = dly(D0, mn);
      e_st1 = dly(D0 + D1, mn);
      e_ov  = dly(TOT, mn);
      e_tw0 = e_st0 ? (run_len(D0, mn) - 1) % FR : 0;
      e_tw1 = e_st1 ? (run_len(D0 + D1, mn) - 1) % FR : 0;
      e_fs  = e_ov && ((run_len(TOT, mn) - 1) % FR == 0);
      e_err = (mn >= 1) && !in_h[mn-1] && !rst_h[mn-1] && (fi_at(mn - 1) != 0);
      e_empty = 1'b1;
      for (int k = 1; k <= TOT; k++) if (dly(k, mn)) e_empty = 1'b0;

      if (mn >= 2) begin
        check("st_en",       32'(bus.st_en),       32'({e_st1, e_st0}));
        check("bf_ctrl",     32'(bus.bf_ctrl),     32'({bit'((e_tw1 >> SEL1) & 1), bit'((e_tw0 >> SEL0) & 1)}));
        check("tw_addr0",    32'(bus.tw_addr0),    32'(e_tw0));
        check("tw_addr1",    32'(bus.tw_addr1),    32'(e_tw1));
        check("out_valid",   32'(bus.out_valid),   32'(e_ov));
        check("frame_start", 32'(bus.frame_start), 32'(e_fs));
        check("err_partial", 32'(bus.err_partial), 32'(e_err));
        check("busy",        32'(bus.busy),        32'(ms != M_IDLE));
      end

      // Sequencer phase for the next cycle, from this cycle's inputs.
      if (rst) ms = M_IDLE;
      else begin
        case (ms)
          M_IDLE:  if (bus.in_valid) ms = M_FILL;
          M_FILL:  if (e_ov) ms = M_RUN; else if (!bus.in_valid && e_empty) ms = M_IDLE;
          M_RUN:   if (!bus.in_valid) ms = M_DRAIN;
          default: if (bus.in_valid) ms = M_RUN; else if (e_empty) ms = M_IDLE;
        endcase
      end
    end
  end

  task automatic drive(input logic v, input logic r);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    rst = r;
  endtask

  function automatic int count_err(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (rec_err[i] === 1'b1) c++;
    return c;
  endfunction

  int t, d, r, x, nz;
  logic [3:0] pat_bf0, pat_bf1;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    drive(0, 1);
    drive(0, 1);

    // Idle: 100 cycles with in_valid low after reset.
    for (int i = 0; i < 100; i++) drive(0, 0);
    @(negedge clk);
    nz = 0;
    for (int i = 2; i < 102; i++)
      if (rec_st[i] != 0 || rec_bf[i] != 0 || rec_tw0[i] != 0 || rec_tw1[i] != 0 ||
          rec_ov[i] || rec_fs[i] || rec_busy[i] || rec_err[i]) nz++;
    check("idle_nonzero_cycles", 32'(nz), 32'd0);

    // Fill latency, commutators and addresses: 64 valid cycles.
    drive(1, 0);
    t = cyc;
    for (int i = 0; i < 63; i++) drive(1, 0);
    for (int i = 0; i < 10; i++) drive(0, 0);
    check("fill_st0_t+1",  32'(rec_st[t+1][0]), 32'd0);
    check("fill_st0_t+2",  32'(rec_st[t+2][0]), 32'd1);
    check("fill_st1_t+2",  32'(rec_st[t+2][1]), 32'd0);
    check("fill_st1_t+3",  32'(rec_st[t+3][1]), 32'd1);
    check("fill_ov_t+3",   32'(rec_ov[t+3]),    32'd0);
    check("fill_ov_t+4",   32'(rec_ov[t+4]),    32'd1);
    check("fill_fs_t+4",   32'(rec_fs[t+4]),    32'd1);
    check("fill_fs_t+5",   32'(rec_fs[t+5]),    32'd0);
    check("fill_fs_t+36",  32'(rec_fs[t+36]),   32'd1);
    check("fill_busy_t+1", 32'(rec_busy[t+1]),  32'd1);
    pat_bf0 = 4'b1100;
    pat_bf1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bf0_seq%0d", i), 32'(rec_bf[t+2+i][0]), 32'(pat_bf0[i]));
      check($sformatf("bf1_seq%0d", i), 32'(rec_bf[t+3+i][1]), 32'(pat_bf1[i]));
    end
    check("tw0_last_of_frame", 32'(rec_tw0[t+33]), 32'd31);
    check("tw0_wrap",          32'(rec_tw0[t+34]), 32'd0);

    // Drain after exactly one frame.
    drive(1, 0);
    t = cyc;
    for (int i = 0; i < 31; i++) drive(1, 0);
    for (int i = 0; i < 12; i++) drive(0, 0);
    d = t + 32;
    check("drain_no_err",   32'(count_err(t, d + 6)), 32'd0);
    check("drain_st0_d+1",  32'(rec_st[d+1][0]), 32'd1);
    check("drain_st0_d+2",  32'(rec_st[d+2][0]), 32'd0);
    check("drain_st1_d+3",  32'(rec_st[d+3][1]), 32'd0);
    check("drain_ov_d+3",   32'(rec_ov[d+3]),    32'd1);
    check("drain_ov_d+4",   32'(rec_ov[d+4]),    32'd0);
    check("drain_busy_d+5", 32'(rec_busy[d+5]),  32'd0);

    // Partial frame: 20 valid, 1 gap, then a full frame.
    drive(1, 0);
    t = cyc;
    for (int i = 0; i < 19; i++) drive(1, 0);
    drive(0, 0);
    d = cyc;
    drive(1, 0);
    r = cyc;
    for (int i = 0; i < 31; i++) drive(1, 0);
    for (int i = 0; i < 10; i++) drive(0, 0);
    check("partial_err_d+1",  32'(rec_err[d+1]), 32'd1);
    check("partial_err_once", 32'(count_err(t, r + 38)), 32'd1);
    check("partial_tw0_r",    32'(rec_tw0[r]),   32'd19);
    check("partial_st0_r+1",  32'(rec_st[r+1][0]), 32'd0);
    check("partial_tw0_r+2",  32'(rec_tw0[r+2]), 32'd0);
    check("partial_tw0_r+3",  32'(rec_tw0[r+3]), 32'd1);
    check("partial_ov_r+3",   32'(rec_ov[r+3]),  32'd0);
    check("partial_fs_r+4",   32'(rec_fs[r+4]),  32'd1);

    // Mid-run reset at cycle 30 of a run.
    drive(1, 0);
    t = cyc;
    for (int i = 0; i < 29; i++) drive(1, 0);
    drive(1, 1);
    x = cyc;
    for (int i = 0; i < 5; i++) drive(1, 0);
    for (int i = 0; i < 10; i++) drive(0, 0);
    check("rst_pre_ov",     32'(rec_ov[x]), 32'd1);
    check("rst_st_en",      32'(rec_st[x+1]),  32'd0);
    check("rst_bf_ctrl",    32'(rec_bf[x+1]),  32'd0);
    check("rst_tw_addr0",   32'(rec_tw0[x+1]), 32'd0);
    check("rst_tw_addr1",   32'(rec_tw1[x+1]), 32'd0);
    check("rst_out_valid",  32'(rec_ov[x+1]),  32'd0);
    check("rst_frame_st",   32'(rec_fs[x+1]),  32'd0);
    check("rst_busy",       32'(rec_busy[x+1]), 32'd0);
    check("rst_err",        32'(rec_err[x+1]), 32'd0);

    // Randomised bursts, gaps and occasional resets.
    for (int b = 0; b < 30; b++) begin
      int len, gap;
      len = int'($urandom_range(1, 60));
      gap = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) drive(1, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
      for (int i = 0; i < gap; i++) drive(0, 0);
    end
    for (int i = 0; i < 12; i++) drive(0, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
